goomba_scheduler: RTL

Time-multiplexed movement controller for up to `NUM_GOOMBAS` goombas sharing one background-tile read port. On each `step` pulse it walks every live goomba in index order, probes the two tiles ahead of it (top and bottom rows), reverses direction on a block or screen edge, and otherwise advances it by one pixel. It sits between the movement-clock domain's step generator and the background tile store, and it feeds the per-goomba x positions to the renderer and the collision logic.

---
 rtl/goomba_scheduler_if.sv | 11 +
 rtl/goomba_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/goomba_scheduler_if.sv
// Background tile read port shared by every goomba slot.
// The scheduler issues a registered read strobe; the tile store answers one cycle later.
interface goomba_scheduler_if;
  logic       req;
  int         row;
  int         col;
  logic [7:0] data;

  modport master (output req, output row, output col, input data);
  modport slave  (input req, input row, input col, output data);
endinterface

// File: rtl/goomba_scheduler.sv
// Time-multiplexed goomba movement controller: on each step it walks the live slots,
// probes the two tiles ahead of each one, and either advances it a pixel or turns it around.
module goomba_scheduler #(
  parameter int NUM_GOOMBAS     = 4,
  parameter int BLK             = 2,
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH    = 640,
  parameter int BLOCK_WIDTH     = 40,
  parameter int SPAWN_X         = 100,
  localparam int IW = (NUM_GOOMBAS > 1) ? $clog2(NUM_GOOMBAS) : 1
) (
  input  logic                   movement_clock,
  input  logic                   reset,
  input  logic                   step_i,
  input  int                     goomba_y_i [NUM_GOOMBAS],
  input  logic                   spawn_i,
  input  logic [IW-1:0]          spawn_id_i,
  input  int                     spawn_x_i,
  input  logic [NUM_GOOMBAS-1:0] kill_i,
  goomba_scheduler_if.master     tile,
  output int                     goomba_x_o [NUM_GOOMBAS],
  output logic [NUM_GOOMBAS-1:0] goomba_alive_o,
  output logic [NUM_GOOMBAS-1:0] goomba_dir_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   step_overrun_o
);

  localparam int MAX_ROW = 11;
  localparam int MAX_COL = 16;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PROBE_TOP,
    PROBE_BOT,
    EVAL,
    FINISH
  } state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  int                     x_q [NUM_GOOMBAS];
  logic [NUM_GOOMBAS-1:0] alive_q;
  logic [NUM_GOOMBAS-1:0] dir_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overrun_q;
  logic                   tileReq_q;
  int                     tileRow_q;
  int                     tileCol_q;
  logic                   blockedTop_q;
  logic                   suppress_q;

  int   curX;
  int   curY;
  logic curDir;
  logic atEdge;
  int   probeCol;
  int   topRow;
  int   botRow;
  logic slotHit;
  logic tileBlk;
  logic lastSlot;
  logic advance;

  function automatic int clampInt(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  always_comb begin
    curX     = x_q[idx_q];
    curY     = goomba_y_i[idx_q];
    curDir   = dir_q[idx_q];
    atEdge   = curDir ? (curX + CHARACTER_WIDTH >= SCREEN_WIDTH) : (curX <= 0);
    probeCol = clampInt(curDir ? (curX + 1 + CHARACTER_WIDTH) / BLOCK_WIDTH
                               : (curX - 1) / BLOCK_WIDTH, MAX_COL);
    topRow   = clampInt(curY / BLOCK_WIDTH, MAX_ROW);
    botRow   = clampInt((curY + CHARACTER_WIDTH - 1) / BLOCK_WIDTH, MAX_ROW);
    // A kill or spawn landing on the slot being processed cancels its pending EVAL write.
    slotHit  = kill_i[idx_q] || (spawn_i && (spawn_id_i == idx_q));
    tileBlk  = (tile.data == 8'(BLK));
    lastSlot = (idx_q == IW'(NUM_GOOMBAS - 1));
    advance  = ((state_q == SELECT) && (!alive_q[idx_q] || atEdge)) || (state_q == EVAL);
  end

  always_ff @(posedge movement_clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      for (int i = 0; i < NUM_GOOMBAS; i++) x_q[i] <= SPAWN_X;
      alive_q      <= '0;
      dir_q        <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      tileReq_q    <= 1'b0;
      tileRow_q    <= 0;
      tileCol_q    <= 0;
      blockedTop_q <= 1'b0;
      suppress_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      tileReq_q <= 1'b0;
      overrun_q <= step_i && busy_q;

      case (state_q)
        IDLE: begin
          if (step_i) begin
            idx_q   <= '0;
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (alive_q[idx_q] && atEdge) begin
            dir_q[idx_q] <= ~curDir;
          end else if (alive_q[idx_q]) begin
            state_q    <= PROBE_TOP;
            tileReq_q  <= 1'b1;
            tileRow_q  <= topRow;
            tileCol_q  <= probeCol;
            suppress_q <= slotHit;
          end
        end
        PROBE_TOP: begin
          state_q    <= PROBE_BOT;
          tileReq_q  <= 1'b1;
          tileRow_q  <= botRow;
          suppress_q <= suppress_q || slotHit;
        end
        PROBE_BOT: begin
          state_q      <= EVAL;
          blockedTop_q <= tileBlk;
          suppress_q   <= suppress_q || slotHit;
        end
        EVAL: begin
          if (!(suppress_q || slotHit)) begin
            if (blockedTop_q || tileBlk) dir_q[idx_q] <= ~curDir;
            else if (curDir)             x_q[idx_q]   <= curX + 1;
            else                         x_q[idx_q]   <= curX - 1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (advance) begin
        if (lastSlot) begin
          state_q <= FINISH;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= SELECT;
          idx_q   <= idx_q + IW'(1);
        end
      end

      // Spawn overrides any movement write this cycle; kill then overrides the live flag.
      if (spawn_i) begin
        x_q[spawn_id_i]     <= spawn_x_i;
        dir_q[spawn_id_i]   <= 1'b1;
        alive_q[spawn_id_i] <= 1'b1;
      end
      for (int i = 0; i < NUM_GOOMBAS; i++) begin
        if (kill_i[i]) alive_q[i] <= 1'b0;
      end
    end
  end

  assign tile.req       = tileReq_q;
  assign tile.row       = tileRow_q;
  assign tile.col       = tileCol_q;
  assign goomba_x_o     = x_q;
  assign goomba_alive_o = alive_q;
  assign goomba_dir_o   = dir_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign step_overrun_o = overrun_q;

endmodule
